// File: rtl/trap_ctrl_if.sv
// Signal bundle between the pipeline, the machine CSR bank and the trap sequencer.
// The slave side is the sequencer. The master side is whatever drives requests and holds the bank.
interface trap_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int NCAUSE = 3
);
    logic [NCAUSE-1:0] exc_req;
    logic [XLEN-1:0]   exc_pc;
    logic [XLEN-1:0]   exc_tval;
    logic              mret;
    logic [4:0]        btn;

    logic [XLEN-1:0]   mtevc_q;
    logic [XLEN-1:0]   mcause_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   mtval_q;
    logic [XLEN-1:0]   mipd_q;
    logic [XLEN-1:0]   bs_q;

    logic              csr_we;
    logic [XLEN-1:0]   mtevc_d;
    logic [XLEN-1:0]   mcause_d;
    logic [XLEN-1:0]   mepc_d;
    logic [XLEN-1:0]   mtval_d;
    logic [XLEN-1:0]   mipd_d;
    logic [XLEN-1:0]   bs_d;

    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              stall;
    logic              nest_err;

    modport slave (
        input  exc_req, exc_pc, exc_tval, mret, btn,
        input  mtevc_q, mcause_q, mepc_q, mtval_q, mipd_q, bs_q,
        output csr_we, mtevc_d, mcause_d, mepc_d, mtval_d, mipd_d, bs_d,
        output redirect, redirect_pc, stall, nest_err
    );

    modport master (
        output exc_req, exc_pc, exc_tval, mret, btn,
        output mtevc_q, mcause_q, mepc_q, mtval_q, mipd_q, bs_q,
        input  csr_we, mtevc_d, mcause_d, mepc_d, mtval_d, mipd_d, bs_d,
        input  redirect, redirect_pc, stall, nest_err
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: saves trap context into the machine CSR bank, redirects to the handler,
// and restores on mret. Also publishes the encoded button state into bs.
module trap_ctrl #(
    parameter int XLEN   = 32,
    parameter int NCAUSE = 3
) (
    input  logic       clk,
    input  logic       rstn,
    trap_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        JUMP,
        HANDLE,
        RESTORE,
        RET
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] bs_code_q, bs_code_d;
    logic            nest_q, nest_d;
    logic [XLEN-1:0] exc_cause;

    // Both encoders scan from the top down so the lowest set index ends up winning.
    always_comb begin
        exc_cause = '0;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (bus.exc_req[i]) exc_cause = XLEN'(i + 1);
        end
        bs_code_d = '0;
        for (int i = 4; i >= 0; i--) begin
            if (bus.btn[i]) bs_code_d = XLEN'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cause_q   <= '0;
            pc_q      <= '0;
            tval_q    <= '0;
            bs_code_q <= '0;
            nest_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            tval_q    <= tval_d;
            bs_code_q <= bs_code_d;
            nest_q    <= nest_d;
        end
    end

    // The bank has one write enable for all six registers.
    // Every *_d defaults to its *_q, so a write only changes the fields a state overrides.
    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        tval_d           = tval_q;
        nest_d           = nest_q;
        bus.csr_we       = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.stall        = 1'b0;
        bus.mtevc_d      = bus.mtevc_q;
        bus.mcause_d     = bus.mcause_q;
        bus.mepc_d       = bus.mepc_q;
        bus.mtval_d      = bus.mtval_q;
        bus.mipd_d       = bus.mipd_q;
        bus.bs_d         = bus.bs_q;

        unique case (state_q)
            IDLE: begin
                bus.bs_d = bs_code_q;
                if (|bus.exc_req) begin
                    state_d = SAVE;
                    cause_d = exc_cause;
                    pc_d    = bus.exc_pc;
                    tval_d  = bus.exc_tval;
                end else if (bs_code_q != bus.bs_q) begin
                    bus.csr_we = 1'b1;
                end
            end
            SAVE: begin
                bus.stall    = 1'b1;
                bus.csr_we   = 1'b1;
                bus.mcause_d = cause_q;
                bus.mepc_d   = pc_q;
                bus.mtval_d  = tval_q;
                bus.mipd_d   = '0;
                state_d      = JUMP;
            end
            JUMP: begin
                bus.stall       = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = bus.mtevc_q;
                state_d         = HANDLE;
            end
            HANDLE: begin
                if (|bus.exc_req) nest_d = 1'b1;
                if (bus.mret) state_d = RESTORE;
            end
            RESTORE: begin
                bus.stall  = 1'b1;
                bus.csr_we = 1'b1;
                bus.mipd_d = XLEN'(1);
                state_d    = RET;
            end
            RET: begin
                bus.stall       = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = bus.mepc_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.nest_err = nest_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl, with a small CSR bank model that
// captures *_d on csr_we and can be written by the "handler" to move mepc.
module tb_trap_ctrl;

    logic clk;
    logic rstn;
    int   checkCount;
    int   failCount;

    trap_ctrl_if #(.XLEN(32), .NCAUSE(3)) bus ();

    trap_ctrl #(.XLEN(32), .NCAUSE(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    logic [31:0] mtevcReg, mcauseReg, mepcReg, mtvalReg, mipdReg, bsReg;
    logic        handlerWrite;
    logic [31:0] handlerMepc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank registers reset to known values; mtevc holds the handler base.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtevcReg  <= 32'h800;
            mcauseReg <= '0;
            mepcReg   <= '0;
            mtvalReg  <= '0;
            mipdReg   <= '0;
            bsReg     <= '0;
        end else if (bus.csr_we) begin
            mtevcReg  <= bus.mtevc_d;
            mcauseReg <= bus.mcause_d;
            mepcReg   <= bus.mepc_d;
            mtvalReg  <= bus.mtval_d;
            mipdReg   <= bus.mipd_d;
            bsReg     <= bus.bs_d;
        end else if (handlerWrite) begin
            mepcReg   <= handlerMepc;
        end
    end

    assign bus.mtevc_q  = mtevcReg;
    assign bus.mcause_q = mcauseReg;
    assign bus.mepc_q   = mepcReg;
    assign bus.mtval_q  = mtvalReg;
    assign bus.mipd_q   = mipdReg;
    assign bus.bs_q     = bsReg;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, drive the inputs, then let them settle.
    task automatic applyStimulus(input logic [2:0] exc, input logic mretIn, input logic [4:0] btnIn);
        @(posedge clk);
        #1;
        bus.exc_req = exc;
        bus.mret    = mretIn;
        bus.btn     = btnIn;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount   = 0;
        failCount    = 0;
        rstn         = 1'b0;
        handlerWrite = 1'b0;
        handlerMepc  = '0;
        bus.exc_req  = '0;
        bus.exc_pc   = '0;
        bus.exc_tval = '0;
        bus.mret     = 1'b0;
        bus.btn      = '0;
        #12;
        checkOutput("rst_csr_we", {31'd0, bus.csr_we}, 32'd0);
        checkOutput("rst_redirect", {31'd0, bus.redirect}, 32'd0);
        checkOutput("rst_redirect_pc", bus.redirect_pc, 32'd0);
        checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
        checkOutput("rst_nest_err", {31'd0, bus.nest_err}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Trap 1: divide-by-zero style request on bit 1
        bus.exc_pc   = 32'h100;
        bus.exc_tval = 32'h0;
        applyStimulus(3'b010, 1'b0, 5'b0);
        checkOutput("t1_idle_csr_we", {31'd0, bus.csr_we}, 32'd0);
        checkOutput("t1_idle_stall", {31'd0, bus.stall}, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t1_save_csr_we", {31'd0, bus.csr_we}, 32'd1);
        checkOutput("t1_save_mcause", bus.mcause_d, 32'd2);
        checkOutput("t1_save_mepc", bus.mepc_d, 32'h100);
        checkOutput("t1_save_mtval", bus.mtval_d, 32'h0);
        checkOutput("t1_save_mipd", bus.mipd_d, 32'd0);
        checkOutput("t1_save_mtevc", bus.mtevc_d, 32'h800);
        checkOutput("t1_save_stall", {31'd0, bus.stall}, 32'd1);
        checkOutput("t1_save_redirect", {31'd0, bus.redirect}, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t1_jump_redirect", {31'd0, bus.redirect}, 32'd1);
        checkOutput("t1_jump_pc", bus.redirect_pc, 32'h800);
        checkOutput("t1_jump_csr_we", {31'd0, bus.csr_we}, 32'd0);
        checkOutput("t1_jump_stall", {31'd0, bus.stall}, 32'd1);
        applyStimulus(3'b000, 1'b0, 5'b0);
        handlerWrite = 1'b1;
        handlerMepc  = 32'h104;
        checkOutput("t1_handle_stall", {31'd0, bus.stall}, 32'd0);
        checkOutput("t1_handle_redirect", {31'd0, bus.redirect}, 32'd0);
        checkOutput("t1_bank_mcause", mcauseReg, 32'd2);
        applyStimulus(3'b000, 1'b1, 5'b0);
        handlerWrite = 1'b0;
        checkOutput("t1_mret_csr_we", {31'd0, bus.csr_we}, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t1_restore_csr_we", {31'd0, bus.csr_we}, 32'd1);
        checkOutput("t1_restore_mipd", bus.mipd_d, 32'd1);
        checkOutput("t1_restore_mepc", bus.mepc_d, 32'h104);
        checkOutput("t1_restore_mcause", bus.mcause_d, 32'd2);
        checkOutput("t1_restore_stall", {31'd0, bus.stall}, 32'd1);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t1_ret_redirect", {31'd0, bus.redirect}, 32'd1);
        checkOutput("t1_ret_pc", bus.redirect_pc, 32'h104);
        checkOutput("t1_ret_bank_mipd", mipdReg, 32'd1);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t1_idle_stall_after", {31'd0, bus.stall}, 32'd0);
        checkOutput("t1_idle_redirect_after", {31'd0, bus.redirect}, 32'd0);
        checkOutput("t1_nest_clear", {31'd0, bus.nest_err}, 32'd0);

        // Trap 2: bit 1 beats bit 2, nested requests in the handler
        bus.exc_pc   = 32'h200;
        bus.exc_tval = 32'h33;
        applyStimulus(3'b110, 1'b0, 5'b0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t2_save_mcause", bus.mcause_d, 32'd2);
        checkOutput("t2_save_mtval", bus.mtval_d, 32'h33);
        applyStimulus(3'b000, 1'b0, 5'b0);
        applyStimulus(3'b100, 1'b0, 5'b0);
        checkOutput("t2_nest_csr_we", {31'd0, bus.csr_we}, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t2_nest_err", {31'd0, bus.nest_err}, 32'd1);
        checkOutput("t2_nest_no_write", {31'd0, bus.csr_we}, 32'd0);
        checkOutput("t2_nest_no_redirect", {31'd0, bus.redirect}, 32'd0);
        applyStimulus(3'b001, 1'b1, 5'b0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t2_restore_csr_we", {31'd0, bus.csr_we}, 32'd1);
        checkOutput("t2_restore_mcause", bus.mcause_d, 32'd2);
        checkOutput("t2_restore_nest", {31'd0, bus.nest_err}, 32'd1);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t2_ret_pc", bus.redirect_pc, 32'h200);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t2_nest_sticky", {31'd0, bus.nest_err}, 32'd1);

        // Trap 3: bit 0 wins, then reset during JUMP
        bus.exc_pc   = 32'h300;
        bus.exc_tval = 32'h44;
        applyStimulus(3'b011, 1'b0, 5'b0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t3_save_mcause", bus.mcause_d, 32'd1);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t3_jump_redirect", {31'd0, bus.redirect}, 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("t3_rst_redirect", {31'd0, bus.redirect}, 32'd0);
        checkOutput("t3_rst_pc", bus.redirect_pc, 32'd0);
        checkOutput("t3_rst_stall", {31'd0, bus.stall}, 32'd0);
        checkOutput("t3_rst_csr_we", {31'd0, bus.csr_we}, 32'd0);
        checkOutput("t3_rst_nest", {31'd0, bus.nest_err}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus(3'b000, 1'b1, 5'b0);
        applyStimulus(3'b000, 1'b0, 5'b0);
        checkOutput("t3_mret_ignored_we", {31'd0, bus.csr_we}, 32'd0);
        checkOutput("t3_mret_ignored_redirect", {31'd0, bus.redirect}, 32'd0);
        checkOutput("t3_mret_ignored_stall", {31'd0, bus.stall}, 32'd0);

        // Buttons: down+left encodes to down, one pulse per change
        applyStimulus(3'b000, 1'b0, 5'b00110);
        checkOutput("b1_not_yet", {31'd0, bus.csr_we}, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b00110);
        checkOutput("b1_pulse", {31'd0, bus.csr_we}, 32'd1);
        checkOutput("b1_bs_d", bus.bs_d, 32'd2);
        checkOutput("b1_mipd_keep", bus.mipd_d, mipdReg);
        checkOutput("b1_mcause_keep", bus.mcause_d, mcauseReg);
        applyStimulus(3'b000, 1'b0, 5'b00110);
        checkOutput("b1_held", {31'd0, bus.csr_we}, 32'd0);
        checkOutput("b1_bank_bs", bsReg, 32'd2);
        applyStimulus(3'b000, 1'b0, 5'b00000);
        checkOutput("b1_held2", {31'd0, bus.csr_we}, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b00000);
        checkOutput("b2_release_pulse", {31'd0, bus.csr_we}, 32'd1);
        checkOutput("b2_bs_d", bus.bs_d, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b00000);
        checkOutput("b2_release_held", {31'd0, bus.csr_we}, 32'd0);

        // Button change colliding with a trap start is deferred until IDLE
        bus.exc_pc   = 32'h400;
        bus.exc_tval = 32'h0;
        applyStimulus(3'b000, 1'b0, 5'b10001);
        applyStimulus(3'b001, 1'b0, 5'b10000);
        checkOutput("b3_trap_priority", {31'd0, bus.csr_we}, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b10000);
        checkOutput("b3_save_bs_keep", bus.bs_d, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b10000);
        applyStimulus(3'b000, 1'b1, 5'b10000);
        applyStimulus(3'b000, 1'b0, 5'b10000);
        checkOutput("b3_restore_bs_keep", bus.bs_d, 32'd0);
        applyStimulus(3'b000, 1'b0, 5'b10000);
        applyStimulus(3'b000, 1'b0, 5'b10000);
        checkOutput("b3_deferred_pulse", {31'd0, bus.csr_we}, 32'd1);
        checkOutput("b3_deferred_bs_d", bus.bs_d, 32'd5);
        applyStimulus(3'b000, 1'b0, 5'b10000);
        checkOutput("b3_deferred_done", {31'd0, bus.csr_we}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
